// File: rtl/ingress_pkt_buffer.sv
// Per-port ingress packet FIFO: holds whole packets and presents the head word first-word-fall-through.
// Define ING_DROP_EN to discard packets that overflow the buffer instead of back-pressuring the port.
module ingress_pkt_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ready,
  output logic                  vld,
  output logic                  sop,
  output logic                  eop,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  next_data,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;
  logic [DATA_WIDTH+1:0] mem [DEPTH];
  logic [DATA_WIDTH+1:0] head;
  logic [PW-1:0]         wr_addr;
  logic                  wr_en, commit, drop_inc, room;
  logic                  full, accept, pop, pop_eop;

  function automatic logic ptr_full(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return (a[PW-1] != b[PW-1]) && (a[ADDR_WIDTH-1:0] == b[ADDR_WIDTH-1:0]);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign full = ptr_full(wr_ptr_q, rd_ptr_q);

`ifdef ING_DROP_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = !full;
`endif

  assign accept = in_vld && in_ready;

  // Head word is only exposed once committed, so stale storage never leaks after reset.
  assign head     = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign vld      = (rd_ptr_q != commit_ptr_q);
  assign data_out = vld ? head[DATA_WIDTH-1:0] : '0;
  assign sop      = vld && head[DATA_WIDTH+1];
  assign eop      = vld && head[DATA_WIDTH];
  assign ready    = (pkt_count_q != '0);
  assign pop      = next_data && vld;
  assign pop_eop  = pop && head[DATA_WIDTH];

  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_addr      = wr_ptr_q;
    wr_en        = 1'b0;
    commit       = 1'b0;
    drop_inc     = 1'b0;
    room         = 1'b1;
    if (accept) begin
      // A header always restarts at the commit point, discarding any open partial packet.
      if (in_sop) begin
        wr_addr  = commit_ptr_q;
        drop_inc = (state_q == RECV);
      end
      if (in_sop || state_q == RECV) begin
`ifdef ING_DROP_EN
        room = !ptr_full(wr_addr, rd_ptr_q);
`endif
        if (!room) begin
          wr_ptr_d = commit_ptr_q;
          drop_inc = 1'b1;
          state_d  = in_eop ? IDLE : DROP;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_addr + 1'b1;
          if (in_eop) begin
            commit       = 1'b1;
            commit_ptr_d = wr_addr + 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = RECV;
          end
        end
      end else if (state_q == DROP && in_eop) begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    rd_ptr_d     = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    drop_count_d = drop_inc ? sat_inc(drop_count_q) : drop_count_q;
    pkt_count_d  = pkt_count_q;
    if (commit && !pop_eop) begin
      pkt_count_d = pkt_count_q + 1'b1;
    end else if (!commit && pop_eop) begin
      pkt_count_d = pkt_count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[ADDR_WIDTH-1:0]] <= {in_sop, in_eop, in_data};
    end
  end

endmodule

// File: tb/tb_ingress_pkt_buffer.sv
// Bench for ingress_pkt_buffer: directed packets checked against a queue-based packet model every cycle.
module tb_ingress_pkt_buffer;

  localparam int DW = 64, AW = 6, CW = 8, DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0, next_data = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, ready, vld, sop, eop;
  logic [DW-1:0] data_out;
  logic [CW-1:0] pkt_count, drop_count;

  ingress_pkt_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_ready(in_ready), .ready(ready), .vld(vld), .sop(sop),
    .eop(eop), .data_out(data_out), .next_data(next_data),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_pop = 0;

  // Model: committed words in cq, open packet in pend; state 0 idle, 1 receiving, 2 discarding.
  logic [DW+1:0] cq[$], pend[$];
  int mstate = 0, mdrop = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_pkts();
    int n = 0;
    foreach (cq[i]) if (cq[i][DW]) n++;
    return n;
  endfunction

  function automatic logic m_in_ready();
`ifdef ING_DROP_EN
    return 1'b1;
`else
    return (cq.size() + pend.size()) < DEPTH;
`endif
  endfunction

  logic [DW+1:0] w;
  int  csz, tot;
  bit  acc, roomok, aborted;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cq.delete(); pend.delete(); mstate = 0; mdrop = 0;
    end else begin
      csz = cq.size();
      tot = cq.size() + pend.size();
      acc = in_vld && m_in_ready();
      w   = {in_sop, in_eop, in_data};
      if (next_data && csz > 0) begin
        void'(cq.pop_front());
        n_pop++;
      end
      if (acc && (in_sop || mstate == 1)) begin
        aborted = in_sop && mstate == 1;
        if (in_sop) pend.delete();
`ifdef ING_DROP_EN
        roomok = in_sop ? (csz < DEPTH) : (tot < DEPTH);
`else
        roomok = 1'b1;
`endif
        if (!roomok) begin
          pend.delete();
          mdrop  = (mdrop < 255) ? mdrop + 1 : 255;
          mstate = in_eop ? 0 : 2;
        end else begin
          if (aborted) mdrop = (mdrop < 255) ? mdrop + 1 : 255;
          pend.push_back(w);
          if (in_eop) begin
            foreach (pend[i]) cq.push_back(pend[i]);
            pend.delete();
            mstate = 0;
          end else begin
            mstate = 1;
          end
        end
      end else if (acc && mstate == 2 && in_eop) begin
        mstate = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("in_ready", in_ready, m_in_ready());
      check("ready", ready, m_pkts() > 0);
      check("vld", vld, cq.size() > 0);
      check("pkt_count", pkt_count, m_pkts());
      check("drop_count", drop_count, mdrop);
      if (cq.size() > 0) begin
        check("data_out", data_out, cq[0][DW-1:0]);
        check("sop", sop, cq[0][DW+1]);
        check("eop", eop, cq[0][DW]);
      end
    end
  end

  task automatic cyc(input logic v, input logic s, input logic e, input logic [DW-1:0] d, input logic nd);
    in_vld = v; in_sop = s; in_eop = e; in_data = d; next_data = nd;
    @(posedge clk); #1;
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; next_data = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && cq.size() > 0; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("drain_done", cq.size(), 0);
  endtask

  int p0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_ready", ready, 0);
    check("rst_vld", vld, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_drop", drop_count, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 4-word packet: not ready until after eop
    cyc(1, 1, 0, 64'h100, 0); check("t1_ready_w0", ready, 0);
    cyc(1, 0, 0, 64'h101, 0); check("t1_ready_w1", ready, 0);
    cyc(1, 0, 0, 64'h102, 0); check("t1_ready_w2", ready, 0);
    cyc(1, 0, 1, 64'h103, 0);
    check("t1_ready", ready, 1);
    check("t1_pkt", pkt_count, 1);
    check("t1_data", data_out, 64'h100);
    check("t1_sop", sop, 1);

    for (int i = 0; i < 4; i++) begin
      check("t2_data", data_out, 64'h100 + i);
      check("t2_eop", eop, (i == 3));
      cyc(0, 0, 0, '0, 1);
    end
    check("t2_ready", ready, 0);
    check("t2_vld", vld, 0);
    check("t2_pkt", pkt_count, 0);

    // 32 packets while popping: pointers wrap past 2*DEPTH
    p0 = n_pop;
    for (int p = 0; p < 32; p++)
      for (int j = 0; j < 4; j++)
        cyc(1, j == 0, j == 3, 64'h3000 + p * 16 + j, 1);
    drain();
    check("t3_pops", n_pop - p0, 128);
    check("t3_pkt", pkt_count, 0);

    // header inside an open packet aborts it
    cyc(1, 1, 0, 64'h400, 0);
    cyc(1, 0, 0, 64'h401, 0);
    cyc(1, 1, 0, 64'h500, 0);
    cyc(1, 0, 0, 64'h501, 0);
    cyc(1, 0, 1, 64'h502, 0);
    check("t4_drop", drop_count, 1);
    check("t4_pkt", pkt_count, 1);
    check("t4_data", data_out, 64'h500);
    p0 = n_pop;
    drain();
    check("t4_pops", n_pop - p0, 3);

`ifdef ING_DROP_EN
    for (int p = 0; p < 15; p++)
      for (int j = 0; j < 4; j++)
        cyc(1, j == 0, j == 3, 64'h600 + p * 4 + j, 0);
    for (int j = 0; j < 70; j++) cyc(1, j == 0, j == 69, 64'h700 + j, 0);
    check("t5_drop", drop_count, 2);
    check("t5_pkt", pkt_count, 15);
    check("t5_in_ready", in_ready, 1);
    p0 = n_pop;
    drain();
    check("t5_pops", n_pop - p0, 60);
`else
    for (int p = 0; p < 16; p++)
      for (int j = 0; j < 4; j++)
        cyc(1, j == 0, j == 3, 64'h600 + p * 4 + j, 0);
    check("t5_full_in_ready", in_ready, 0);
    check("t5_pkt", pkt_count, 16);
    cyc(1, 1, 1, 64'hDEAD, 0);
    check("t5_rejected_pkt", pkt_count, 16);
    cyc(0, 0, 0, '0, 1);
    check("t5_in_ready_after_pop", in_ready, 1);
    p0 = n_pop;
    drain();
    check("t5_pops", n_pop - p0, 63);
`endif

    // reset mid-read and mid-packet
    cyc(1, 1, 0, 64'h800, 0);
    cyc(1, 0, 1, 64'h801, 0);
    cyc(0, 0, 0, '0, 1);
    cyc(1, 1, 0, 64'h900, 0);
    rst = 1'b0;
    #1;
    check("t6_ready", ready, 0);
    check("t6_vld", vld, 0);
    check("t6_sop", sop, 0);
    check("t6_eop", eop, 0);
    check("t6_data", data_out, 0);
    check("t6_pkt", pkt_count, 0);
    check("t6_drop", drop_count, 0);
    check("t6_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(1, 1, 1, 64'hABC, 0);
    check("t6_1w_vld", vld, 1);
    check("t6_1w_data", data_out, 64'hABC);
    check("t6_1w_sop", sop, 1);
    check("t6_1w_eop", eop, 1);
    check("t6_1w_pkt", pkt_count, 1);
    cyc(0, 0, 0, '0, 1);
    check("t6_after_vld", vld, 0);
    check("t6_after_pkt", pkt_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
